ddr_rd_burst_arb: RTL
=====================

# ddr_rd_burst_arb

Round-robin arbiter sharing the single DDR read-burst port (rd_burst_req/len/addr, data_valid/data/finish) among NUM_REQ read clients, e.g. FIR-coefficient readback, frame readback and calibration fetch. It sits between the clients and the DDR3 user-interface read channel in the ddr_clk domain. It holds one burst in flight, latches the winner's length and address, routes beats and finish back to that client only, and checks the beat count against the requested length.

## Interface
- NUM_REQ, 4, number of clients (2..8)
- DDR_DATA_WD, 512, beat width
- DDR_ADDR_WD, 32, burst address width
- ddr_clk  in  1  DDR user clock; only clock
- ddr_rst_n  in  1  asynchronous active-low reset
- req_burst_req  in  NUM_REQ  per-client request; held until that client sees its finish
- req_burst_len  in  NUM_REQ*10  per-client beat count, client i at [i*10+:10]
- req_burst_addr  in  NUM_REQ*DDR_ADDR_WD  per-client start address
- req_burst_data_valid  out  NUM_REQ  beat strobe, granted client only
- req_burst_data  out  DDR_DATA_WD  beat data, broadcast to all clients
- req_burst_finish  out  NUM_REQ  end-of-burst pulse, granted client only
- rd_burst_req  out  1  to DDR controller
- rd_burst_len  out  10  latched length
- rd_burst_addr  out  DDR_ADDR_WD  latched address
- rd_burst_data_valid  in  1  from DDR controller
- rd_burst_data  in  DDR_DATA_WD  from DDR controller
- rd_burst_finish  in  1  from DDR controller
- gnt_id  out  $clog2(NUM_REQ)  current or last grantee
- busy  out  1  high in ISSUE and DONE
- len_err  out  1  one-cycle pulse, beat count mismatch
- len_err_cnt  out  16  saturating mismatch counter

## Operation
- States: IDLE, ISSUE, DONE.
- IDLE: if any req_burst_req bit is set, pick the first set bit searching upward (wrapping) from last_gnt+1. Latch gnt_id, rd_burst_len and rd_burst_addr from that client. Clear beat_cnt. Go to ISSUE.
- ISSUE: rd_burst_req=1; len/addr stay constant for the whole state. Each rd_burst_data_valid increments beat_cnt (10 bits, wraps).
  - On rd_burst_finish: compare beat_cnt plus the same-cycle valid against rd_burst_len. On mismatch, pulse len_err in DONE and increment len_err_cnt, saturating at 16'hFFFF. Set last_gnt=gnt_id. Go to DONE.
- DONE: one cycle, then IDLE. This gives the finished client time to drop its request before re-arbitration.
- Routing (combinational, ISSUE only):
  - req_burst_data_valid[gnt_id] = rd_burst_data_valid.
  - req_burst_finish[gnt_id] = rd_burst_finish.
  - All other bits are 0.
  - req_burst_data = rd_burst_data, always.
- Beats or finish arriving outside ISSUE are dropped and not counted.
- A client deasserting its request mid-ISSUE does not abort the burst; it runs to finish.
- len 0 is legal: the burst is issued, and a finish with zero beats is not an error.
- Only one burst is ever outstanding.

## Timing
- Reset (async assert, release on a ddr_clk edge):
  - State goes to IDLE; last_gnt = NUM_REQ-1, so client 0 wins first.
  - rd_burst_req, rd_burst_len, rd_burst_addr = 0.
  - gnt_id = 0; busy = 0; len_err = 0; len_err_cnt = 0.
  - req_burst_data_valid and req_burst_finish = 0.
- Reset mid-burst abandons the burst immediately. Any beats from the controller after release are dropped.
- Request to issue: client request sampled high in IDLE at cycle 0 -> rd_burst_req high from cycle 1.
- Finish to finish: routed with 0 cycles of latency.
- Back-to-back: finish at cycle F -> DONE at F+1 -> IDLE at F+2 -> next rd_burst_req at F+3.
- Same-cycle valid and finish: the beat is forwarded and included in the length check.
- The registered outputs rd_burst_* are glitch-free. Only the two routing outputs are combinational from DDR inputs.

## Test plan
- Single client: client 2 requests len=8, addr=32'h0000_1000; controller returns 8 beats and finishes with the last beat -> rd_burst_req high from cycle 1, 8 valids only on bit 2, finish on bit 2, len_err=0, gnt_id=2.
- Fairness: all 4 clients hold requests continuously, each len=4 -> grant order 0,1,2,3,0,1; burst starts spaced exactly (4 beats + finish + 3) cycles apart; no client starved.
- Length mismatch: len=8, controller returns 6 beats then finishes -> len_err pulses one cycle in DONE, len_err_cnt=1; preset count 16'hFFFF plus another mismatch -> stays at 16'hFFFF.
- Stray/abort: rd_burst_data_valid pulsed in IDLE -> no req_burst_data_valid bit set. Client 1 drops its request mid-burst -> rd_burst_req stays high until finish, finish still routed to bit 1.
- Zero length: len=0, finish with no beats -> len_err=0, returns to IDLE through DONE.
- Reset mid-burst: assert ddr_rst_n=0 after 3 of 8 beats -> all outputs take reset values asynchronously. After release, client 0 (if requesting) wins first; leftover beats are ignored.

Source files
------------

// File: rtl/ddr_rd_burst_arb_if.sv
// ddr_rd_burst_arb_if
// Bundles the client-side read-burst ports and the single DDR user-interface read
// channel that ddr_rd_burst_arb multiplexes.
//   master : the arbiter side. Takes client requests and controller beats, and drives
//            the DDR request and the per-client beat/finish strobes.
//   slave  : the environment side. This is the clients plus the DDR controller.
// Signals:
//   req_burst_req/len/addr            client requests. Client i len at [i*10+:10].
//   req_burst_data_valid/data/finish  beats routed back to the clients.
//   rd_burst_req/len/addr             burst request to the DDR controller.
//   rd_burst_data_valid/data/finish   beats returned by the DDR controller.
interface ddr_rd_burst_arb_if #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DDR_DATA_WD = 512,
    parameter int unsigned DDR_ADDR_WD = 32
);
    logic [NUM_REQ-1:0]             req_burst_req;
    logic [NUM_REQ*10-1:0]          req_burst_len;
    logic [NUM_REQ*DDR_ADDR_WD-1:0] req_burst_addr;
    logic [NUM_REQ-1:0]             req_burst_data_valid;
    logic [DDR_DATA_WD-1:0]         req_burst_data;
    logic [NUM_REQ-1:0]             req_burst_finish;

    logic                           rd_burst_req;
    logic [9:0]                     rd_burst_len;
    logic [DDR_ADDR_WD-1:0]         rd_burst_addr;
    logic                           rd_burst_data_valid;
    logic [DDR_DATA_WD-1:0]         rd_burst_data;
    logic                           rd_burst_finish;

    modport master (
        input  req_burst_req, req_burst_len, req_burst_addr,
        input  rd_burst_data_valid, rd_burst_data, rd_burst_finish,
        output req_burst_data_valid, req_burst_data, req_burst_finish,
        output rd_burst_req, rd_burst_len, rd_burst_addr
    );

    modport slave (
        output req_burst_req, req_burst_len, req_burst_addr,
        output rd_burst_data_valid, rd_burst_data, rd_burst_finish,
        input  req_burst_data_valid, req_burst_data, req_burst_finish,
        input  rd_burst_req, rd_burst_len, rd_burst_addr
    );
endinterface

// File: rtl/ddr_rd_burst_arb.sv
// ddr_rd_burst_arb
// Round-robin arbiter that shares one DDR read-burst port among NUM_REQ clients.
// At most one burst is in flight. The winner's length and address are latched. Beats
// and finish are routed only to the winner, and the number of beats is checked
// against the requested length.
// Ports:
//   i_ddr_clk      DDR user clock
//   i_ddr_rst_n    asynchronous active-low reset
//   bus            client and DDR read channel bundle (master side)
//   o_gnt_id       current or most recent grantee
//   o_busy         burst in flight or in its one-cycle wind-down
//   o_len_err      one-cycle pulse when the beat count differs from the length
//   o_len_err_cnt  saturating count of length mismatches
module ddr_rd_burst_arb #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DDR_DATA_WD = 512,
    parameter int unsigned DDR_ADDR_WD = 32
) (
    input  logic                       i_ddr_clk,
    input  logic                       i_ddr_rst_n,
    ddr_rd_burst_arb_if.master         bus,
    output logic [$clog2(NUM_REQ)-1:0] o_gnt_id,
    output logic                       o_busy,
    output logic                       o_len_err,
    output logic [15:0]                o_len_err_cnt
);
    localparam int unsigned GNT_WD = $clog2(NUM_REQ);

    typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

    state_e                 r_state;
    state_e                 w_state_d;
    logic [GNT_WD-1:0]      r_gnt_id;
    logic [GNT_WD-1:0]      r_last_gnt;
    logic [9:0]             r_len;
    logic [DDR_ADDR_WD-1:0] r_addr;
    logic [9:0]             r_beat_cnt;
    logic                   r_rd_req;
    logic                   r_busy;
    logic                   r_len_err;
    logic [15:0]            r_len_err_cnt;

    logic                   w_any;
    logic [GNT_WD-1:0]      w_cand;
    logic [GNT_WD-1:0]      w_pick;
    logic [9:0]             w_pick_len;
    logic [DDR_ADDR_WD-1:0] w_pick_addr;
    logic [9:0]             w_beat_total;
    logic                   w_mismatch;
    logic [NUM_REQ-1:0]     w_dv;
    logic [NUM_REQ-1:0]     w_fin;

    // Round-robin pick. Candidates are visited from the farthest offset (last_gnt
    // itself) down to the nearest (last_gnt+1). The last hit wins, so the nearest
    // requester after the previous grantee gets the grant.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_cand = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_cand = GNT_WD'((32'(r_last_gnt) + NUM_REQ + 1 - k) % NUM_REQ);
            if (bus.req_burst_req[w_cand]) begin
                w_any  = 1'b1;
                w_pick = w_cand;
            end
        end
    end

    // Select the winner's length and address.
    always_comb begin
        w_pick_len  = '0;
        w_pick_addr = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_pick == GNT_WD'(i)) begin
                w_pick_len  = bus.req_burst_len[i*10 +: 10];
                w_pick_addr = bus.req_burst_addr[i*DDR_ADDR_WD +: DDR_ADDR_WD];
            end
        end
    end

    // A beat that arrives in the same cycle as finish still counts.
    assign w_beat_total = r_beat_cnt + 10'(bus.rd_burst_data_valid);
    assign w_mismatch   = (w_beat_total != r_len);

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:  if (w_any) w_state_d = StIssue;
            StIssue: if (bus.rd_burst_finish) w_state_d = StDone;
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_ddr_clk or negedge i_ddr_rst_n) begin
        if (!i_ddr_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge i_ddr_clk or negedge i_ddr_rst_n) begin
        if (!i_ddr_rst_n) begin
            r_gnt_id      <= '0;
            r_last_gnt    <= GNT_WD'(NUM_REQ - 1);
            r_len         <= '0;
            r_addr        <= '0;
            r_beat_cnt    <= '0;
            r_rd_req      <= 1'b0;
            r_busy        <= 1'b0;
            r_len_err     <= 1'b0;
            r_len_err_cnt <= '0;
        end else begin
            // Registered from next state so the DDR-facing request is glitch-free.
            r_rd_req  <= (w_state_d == StIssue);
            r_busy    <= (w_state_d != StIdle);
            r_len_err <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_any) begin
                        r_gnt_id   <= w_pick;
                        r_len      <= w_pick_len;
                        r_addr     <= w_pick_addr;
                        r_beat_cnt <= '0;
                    end
                end
                StIssue: begin
                    if (bus.rd_burst_data_valid) begin
                        r_beat_cnt <= r_beat_cnt + 10'd1;
                    end
                    if (bus.rd_burst_finish) begin
                        r_last_gnt <= r_gnt_id;
                        if (w_mismatch) begin
                            r_len_err <= 1'b1;
                            if (r_len_err_cnt != 16'hFFFF) begin
                                r_len_err_cnt <= r_len_err_cnt + 16'd1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Beats and finish reach only the grantee, and only while the burst is in flight.
    always_comb begin
        w_dv  = '0;
        w_fin = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (r_state == StIssue && r_gnt_id == GNT_WD'(i)) begin
                w_dv[i]  = bus.rd_burst_data_valid;
                w_fin[i] = bus.rd_burst_finish;
            end
        end
    end

    assign bus.req_burst_data_valid = w_dv;
    assign bus.req_burst_finish     = w_fin;
    assign bus.req_burst_data       = bus.rd_burst_data;
    assign bus.rd_burst_req         = r_rd_req;
    assign bus.rd_burst_len         = r_len;
    assign bus.rd_burst_addr        = r_addr;

    assign o_gnt_id      = r_gnt_id;
    assign o_busy        = r_busy;
    assign o_len_err     = r_len_err;
    assign o_len_err_cnt = r_len_err_cnt;
endmodule
